// File: rtl/network_source_sched_pkg.sv
// source_config: opcodes, packet field widths and saturating add shared by the source scheduler
`ifndef SRC_WIDTH
`define SRC_WIDTH 32
`endif
package source_config;
    localparam int NET_NUM_INP = 4;
    localparam int NET_CHARGE_WIDTH = 8;
    localparam int OPC_WIDTH = $clog2(5);
    localparam int IDX_WIDTH = (NET_NUM_INP > 1) ? $clog2(NET_NUM_INP) : 0;
    localparam int SPK_WIDTH = IDX_WIDTH + NET_CHARGE_WIDTH;
    typedef enum logic [OPC_WIDTH-1:0] {NOP, RUN, SPK, CLR, DEC, NUM_OPS} opcode_t;
    function automatic logic signed [NET_CHARGE_WIDTH-1:0] sat_add(
        input logic signed [NET_CHARGE_WIDTH-1:0] a,
        input logic signed [NET_CHARGE_WIDTH-1:0] b,
        output logic clip
    );
        logic [NET_CHARGE_WIDTH:0] s;
        s = {a[NET_CHARGE_WIDTH-1], a} + {b[NET_CHARGE_WIDTH-1], b};
        clip = s[NET_CHARGE_WIDTH] ^ s[NET_CHARGE_WIDTH-1];
        return clip ? {s[NET_CHARGE_WIDTH], {(NET_CHARGE_WIDTH-1){~s[NET_CHARGE_WIDTH]}}}
                    : s[NET_CHARGE_WIDTH-1:0];
    endfunction
endpackage

// File: rtl/network_source_sched_ring.sv
// spike_slot_ring: per-timestep charge slots with scheduled accumulate, step clear and head wrap
module spike_slot_ring
    import source_config::*;
#(
    parameter int DELAY_DEPTH = 8,
    parameter int SAT_ACCUM = 1,
    parameter int DW = 3,
    parameter int IW = 2
) (
    input  logic                               clk,
    input  logic                               arstn,
    input  logic                               step,
    input  logic                               wr_en,
    input  logic [IW-1:0]                      wr_idx,
    input  logic [DW-1:0]                      wr_dly,
    input  logic signed [NET_CHARGE_WIDTH-1:0] wr_val,
    input  logic                               clr,
    output logic signed [NET_CHARGE_WIDTH-1:0] rd_inp [NET_NUM_INP],
    output logic                               clip
);
    logic signed [NET_CHARGE_WIDTH-1:0] slot [DELAY_DEPTH][NET_NUM_INP];
    logic [DW-1:0] head, head_nx, tgt;
    logic signed [NET_CHARGE_WIDTH-1:0] old, sum, wr_new;
    logic sat_clip;
    assign rd_inp = slot[head];
    always_comb begin
        head_nx = (DELAY_DEPTH == 1) ? '0 : head + DW'(step);
        tgt = (DELAY_DEPTH == 1) ? '0 : head_nx + wr_dly;
        // a write into the slot being consumed this cycle starts from the cleared value
        old = (step && tgt == head) ? '0 : slot[tgt][wr_idx];
        sum = sat_add(old, wr_val, sat_clip);
        wr_new = (SAT_ACCUM != 0) ? sum : wr_val;
        clip = wr_en && (SAT_ACCUM != 0) && sat_clip;
    end
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            head <= '0;
            for (int d = 0; d < DELAY_DEPTH; d++)
                for (int i = 0; i < NET_NUM_INP; i++)
                    slot[d][i] <= '0;
        end else if (clr) begin
            head <= '0;
            for (int d = 0; d < DELAY_DEPTH; d++)
                for (int i = 0; i < NET_NUM_INP; i++)
                    slot[d][i] <= '0;
        end else begin
            head <= head_nx;
            if (step)
                for (int i = 0; i < NET_NUM_INP; i++)
                    slot[head][i] <= '0;
            if (wr_en)
                slot[tgt][wr_idx] <= wr_new;
        end
    end
endmodule

// File: rtl/network_source_sched.sv
// network_source_sched: decodes host packets into scheduled network input charges and run steps
`ifndef SRC_WIDTH
`define SRC_WIDTH 32
`endif
module network_source_sched
    import source_config::*;
#(
    parameter int RUN_WIDTH = 16,
    parameter int DELAY_DEPTH = 8,
    parameter int SAT_ACCUM = 1
) (
    input  logic                               clk,
    input  logic                               arstn,
    input  logic                               src_valid,
    output logic                               src_ready,
    input  logic [`SRC_WIDTH-1:0]              src,
    output logic                               out_ready,
    input  logic                               net_ready,
    output logic                               net_valid,
    output logic                               net_arstn,
    output logic signed [NET_CHARGE_WIDTH-1:0] net_inp [NET_NUM_INP],
    output logic                               sat_flag
);
    localparam int DLY_WIDTH = (DELAY_DEPTH > 1) ? $clog2(DELAY_DEPTH) : 0;
    localparam int DW = (DLY_WIDTH > 0) ? DLY_WIDTH : 1;
    localparam int IW = (IDX_WIDTH > 0) ? IDX_WIDTH : 1;
    localparam int PL = `SRC_WIDTH - OPC_WIDTH;
    localparam int PAY = (RUN_WIDTH > SPK_WIDTH + DLY_WIDTH) ? RUN_WIDTH : SPK_WIDTH + DLY_WIDTH;
    if (`SRC_WIDTH < OPC_WIDTH + PAY) begin : g_bad_width
        $error("SRC_WIDTH too small for opcode and payload");
    end
    if (DELAY_DEPTH < 1 || (DELAY_DEPTH & (DELAY_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DELAY_DEPTH must be a power of 2");
    end
    logic [OPC_WIDTH-1:0] op;
    logic [PL-1:0] pl;
    logic [RUN_WIDTH-1:0] run_cnt, count;
    logic [IW-1:0] spk_idx;
    logic [DW-1:0] spk_dly;
    logic signed [NET_CHARGE_WIDTH-1:0] spk_val;
    logic step, clip;
    assign src_ready = run_cnt <= RUN_WIDTH'(1);
    assign net_valid = run_cnt != '0;
    assign step = net_valid && net_ready;
    assign out_ready = op == DEC;
    always_comb begin
        op = (src_valid && src_ready) ? src[`SRC_WIDTH-1 -: OPC_WIDTH] : NOP;
        pl = src[PL-1:0];
        count = pl[PL-1 -: RUN_WIDTH];
        spk_idx = (IDX_WIDTH > 0) ? pl[PL-1 -: IW] : '0;
        spk_dly = (DLY_WIDTH > 0) ? pl[PL-1-IDX_WIDTH -: DW] : '0;
        spk_val = pl[PL-1-IDX_WIDTH-DLY_WIDTH -: NET_CHARGE_WIDTH];
    end
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            run_cnt <= '0;
            net_arstn <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            net_arstn <= op != CLR;
            sat_flag <= (op != CLR) && (sat_flag || clip);
            if (op == CLR)
                run_cnt <= '0;
            else if (op == RUN)
                run_cnt <= (count == '0) ? RUN_WIDTH'(1) : count;
            else if (step)
                run_cnt <= run_cnt - RUN_WIDTH'(1);
        end
    end
    spike_slot_ring #(
        .DELAY_DEPTH(DELAY_DEPTH),
        .SAT_ACCUM(SAT_ACCUM),
        .DW(DW),
        .IW(IW)
    ) u_ring (
        .clk(clk),
        .arstn(arstn),
        .step(step),
        .wr_en(op == SPK),
        .wr_idx(spk_idx),
        .wr_dly(spk_dly),
        .wr_val(spk_val),
        .clr(op == CLR),
        .rd_inp(net_inp),
        .clip(clip)
    );
endmodule

// File: tb/tb_network_source_sched.sv
// tb_network_source_sched: table vectors, corner sequences and random traffic against a step-queue model
`ifndef SRC_WIDTH
`define SRC_WIDTH 32
`endif
module tb_network_source_sched;
    import source_config::*;
    localparam int D = 4;
    localparam int N = NET_NUM_INP;
    localparam int SW = `SRC_WIDTH;
    typedef struct {
        logic v;
        logic [SW-1:0] pkt;
        logic nr;
        logic e_valid;
        logic e_ready;
        logic e_ordy;
        logic [31:0] e_inp;
    } vec_t;
    logic clk = 0, arstn = 1, src_valid = 0, net_ready = 1;
    logic [SW-1:0] src = '0;
    logic src_ready, out_ready, net_valid, net_arstn, sat_flag;
    logic src_ready0, out_ready0, net_valid0, net_arstn0, sat_flag0;
    logic signed [NET_CHARGE_WIDTH-1:0] net_inp [N];
    logic signed [NET_CHARGE_WIDTH-1:0] net_inp0 [N];
    int n_chk = 0, n_fail = 0;
    int rem, msat, marst;
    int pend [D][N];
    vec_t tbl [13];
    always #5 clk = ~clk;
    network_source_sched #(.DELAY_DEPTH(D)) dut (
        .clk(clk), .arstn(arstn), .src_valid(src_valid), .src_ready(src_ready), .src(src),
        .out_ready(out_ready), .net_ready(net_ready), .net_valid(net_valid),
        .net_arstn(net_arstn), .net_inp(net_inp), .sat_flag(sat_flag)
    );
    network_source_sched #(.DELAY_DEPTH(D), .SAT_ACCUM(0)) dut0 (
        .clk(clk), .arstn(arstn), .src_valid(src_valid), .src_ready(src_ready0), .src(src),
        .out_ready(out_ready0), .net_ready(net_ready), .net_valid(net_valid0),
        .net_arstn(net_arstn0), .net_inp(net_inp0), .sat_flag(sat_flag0)
    );
    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    function automatic logic [SW-1:0] mk(input int opc, input int a = 0, input int b = 0, input int c = 0);
        logic [SW-1:0] p;
        p = '0;
        p[SW-1 -: 3] = opc[2:0];
        if (opc == 1) p[SW-4 -: 16] = a[15:0];
        if (opc == 2) begin
            p[SW-4 -: 2] = a[1:0];
            p[SW-6 -: 2] = b[1:0];
            p[SW-8 -: 8] = c[7:0];
        end
        return p;
    endfunction
    task automatic mreset();
        rem = 0;
        msat = 0;
        marst = 0;
        for (int k = 0; k < D; k++) pend[k] = '{default: 0};
    endtask
    // pend[k] holds the charges the k-th upcoming step will deliver
    task automatic mstep();
        int opc, cnt, idx, dl, val, s;
        bit st;
        chk("src_ready", src_ready, rem <= 1);
        chk("net_valid", net_valid, rem > 0);
        chk("net_arstn", net_arstn, marst);
        chk("sat_flag", sat_flag, msat);
        for (int i = 0; i < N; i++) chk($sformatf("net_inp[%0d]", i), net_inp[i], pend[0][i]);
        st = rem > 0 && net_ready;
        opc = (src_valid && rem <= 1) ? int'(src[SW-1 -: 3]) : 0;
        chk("out_ready", out_ready, opc == 4);
        marst = opc != 3;
        if (opc == 3) begin
            rem = 0;
            msat = 0;
            for (int k = 0; k < D; k++) pend[k] = '{default: 0};
        end else begin
            if (st) begin
                for (int k = 0; k < D - 1; k++) pend[k] = pend[k+1];
                pend[D-1] = '{default: 0};
            end
            if (opc == 1) begin
                cnt = int'(src[SW-4 -: 16]);
                rem = (cnt == 0) ? 1 : cnt;
            end else if (st) rem--;
            if (opc == 2) begin
                idx = int'(src[SW-4 -: 2]);
                dl = int'(src[SW-6 -: 2]);
                val = $signed(src[SW-8 -: 8]);
                s = pend[dl][idx] + val;
                if (s > 127) begin s = 127; msat = 1; end
                if (s < -128) begin s = -128; msat = 1; end
                pend[dl][idx] = s;
            end
        end
    endtask
    task automatic cyc();
        @(negedge clk);
        mstep();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [SW-1:0] p);
        src_valid = 1;
        src = p;
        cyc();
        src_valid = 0;
    endtask
    task automatic do_reset();
        arstn = 0;
        #2;
        mreset();
        chk("rst net_arstn", net_arstn, 0);
        chk("rst net_valid", net_valid, 0);
        chk("rst src_ready", src_ready, 1);
        chk("rst sat_flag", sat_flag, 0);
        for (int i = 0; i < N; i++) chk("rst net_inp", net_inp[i], 0);
        @(posedge clk);
        #1;
        arstn = 1;
    endtask
    task automatic run_count(input int cnt, input bit tog, output int steps, output int seen9);
        bit done;
        steps = 0;
        seen9 = 0;
        done = 0;
        send(mk(1, cnt));
        for (int c = 0; c < 40 && !done; c++) begin
            net_ready = tog ? (c % 2 == 0) : 1'b1;
            @(negedge clk);
            if (!net_valid) done = 1;
            else if (net_ready) begin
                steps++;
                if (net_inp[3] == 9 && seen9 == 0) seen9 = steps;
            end
            mstep();
            @(posedge clk);
            #1;
        end
        net_ready = 1;
        chk("run finished in budget", done, 1);
    endtask
    initial begin
        int steps, seen, k, opc;
        logic [SW-1:0] p;
        tbl[0]  = '{1, mk(2, 2, 0, 5), 1, 0, 1, 0, 32'h0000_0000};
        tbl[1]  = '{1, mk(1, 1),       1, 0, 1, 0, 32'h0005_0000};
        tbl[2]  = '{0, '0,             1, 1, 1, 0, 32'h0005_0000};
        tbl[3]  = '{0, '0,             1, 0, 1, 0, 32'h0000_0000};
        tbl[4]  = '{1, mk(2, 1, 2, 7), 1, 0, 1, 0, 32'h0000_0000};
        tbl[5]  = '{1, mk(1, 3),       1, 0, 1, 0, 32'h0000_0000};
        tbl[6]  = '{0, '0,             1, 1, 0, 0, 32'h0000_0000};
        tbl[7]  = '{0, '0,             1, 1, 0, 0, 32'h0000_0000};
        tbl[8]  = '{0, '0,             1, 1, 1, 0, 32'h0000_0700};
        tbl[9]  = '{0, '0,             1, 0, 1, 0, 32'h0000_0000};
        tbl[10] = '{1, mk(4),          1, 0, 1, 1, 32'h0000_0000};
        tbl[11] = '{1, mk(7),          1, 0, 1, 0, 32'h0000_0000};
        tbl[12] = '{0, mk(4),          1, 0, 1, 0, 32'h0000_0000};
        #1;
        do_reset();
        for (int r = 0; r < 13; r++) begin
            src_valid = tbl[r].v;
            src = tbl[r].pkt;
            net_ready = tbl[r].nr;
            @(negedge clk);
            chk($sformatf("tbl%0d net_valid", r), net_valid, tbl[r].e_valid);
            chk($sformatf("tbl%0d src_ready", r), src_ready, tbl[r].e_ready);
            chk($sformatf("tbl%0d out_ready", r), out_ready, tbl[r].e_ordy);
            for (int i = 0; i < N; i++)
                chk($sformatf("tbl%0d net_inp[%0d]", r, i), net_inp[i], $signed(tbl[r].e_inp[8*i +: 8]));
            mstep();
            @(posedge clk);
            #1;
        end
        src_valid = 0;
        run_count(5, 1, steps, seen);
        chk("run5 toggled steps", steps, 5);
        run_count(0, 0, steps, seen);
        chk("run0 steps", steps, 1);
        send(mk(3));
        chk("clr sat_flag", sat_flag, 0);
        send(mk(2, 0, 0, 100));
        send(mk(2, 0, 0, 100));
        chk("sat pos inp0", net_inp[0], 127);
        chk("sat pos flag", sat_flag, 1);
        chk("overwrite pos inp0", net_inp0[0], 100);
        send(mk(3));
        chk("clr sat_flag again", sat_flag, 0);
        send(mk(2, 0, 0, -100));
        send(mk(2, 0, 0, -100));
        chk("sat neg inp0", net_inp[0], -128);
        chk("sat neg flag", sat_flag, 1);
        chk("overwrite neg inp0", net_inp0[0], -100);
        send(mk(3));
        send(mk(1, 1));
        send(mk(2, 3, 3, 9));
        run_count(4, 0, steps, seen);
        chk("wrap steps", steps, 4);
        chk("wrap seen on step", seen, 4);
        send(mk(2, 0, 1, 3));
        send(mk(2, 1, 2, 4));
        send(mk(1, 2));
        cyc();
        send(mk(3));
        chk("abort net_arstn", net_arstn, 0);
        chk("abort net_valid", net_valid, 0);
        for (int i = 0; i < N; i++) chk("abort net_inp", net_inp[i], 0);
        cyc();
        chk("abort net_arstn back", net_arstn, 1);
        send(mk(2, 0, 1, 3));
        send(mk(2, 1, 2, 4));
        send(mk(1, 2));
        cyc();
        do_reset();
        cyc();
        chk("post-rst net_arstn", net_arstn, 1);
        for (int c = 0; c < 600; c++) begin
            net_ready = $urandom_range(0, 3) != 0;
            src_valid = $urandom_range(0, 1) == 1;
            k = $urandom_range(0, 15);
            opc = k < 7 ? 2 : k < 11 ? 1 : k < 12 ? 3 : k < 13 ? 4 : k < 14 ? 0 : $urandom_range(5, 7);
            p = SW'($urandom);
            p[SW-1 -: 3] = opc[2:0];
            if (opc == 1) p[SW-4 -: 16] = 16'($urandom_range(0, 5));
            src = p;
            if ($urandom_range(0, 199) == 0) do_reset();
            else cyc();
        end
        src_valid = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
